// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM among draw engines.
// Define SPRITE_ARB_PRIO0_EN to give requester 0 absolute priority.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic                    rd_valid,
  output logic [ID_W-1:0]         rd_id,
  output logic [DATA_W-1:0]       rd_data
);

`ifdef SPRITE_ARB_PRIO0_EN
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(1);
`else
  localparam logic [ID_W-1:0] PTR_RST = '0;
`endif
  localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win;
  logic            any;
  logic [ID_W-1:0] ptr_nxt;

  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    any = 1'b0;
`ifdef SPRITE_ARB_PRIO0_EN
    if (req[0]) begin
      any = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ - 1; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N_REQ) idx = idx - (N_REQ - 1);
        if (!any && req[ID_W'(idx)]) begin
          any = 1'b1;
          win = ID_W'(idx);
        end
      end
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[ID_W'(idx)]) begin
        any = 1'b1;
        win = ID_W'(idx);
      end
    end
`endif
    gnt = '0;
    if (any) gnt[win] = 1'b1;
  end

  always_comb begin
    ptr_nxt = ptr;
`ifdef SPRITE_ARB_PRIO0_EN
    if (any && win != '0)
      ptr_nxt = (win == LAST) ? ID_W'(1) : win + 1'b1;
`else
    if (any)
      ptr_nxt = (win == LAST) ? '0 : win + 1'b1;
`endif
  end

  // Stage 0 rides with rom_address; ROM_LAT more stages match rom_q.
  logic [ROM_LAT:0]           vld_q;
  logic [ROM_LAT:0][ID_W-1:0] id_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= PTR_RST;
      rom_address <= '0;
      vld_q       <= '0;
      id_q        <= '0;
    end else begin
      ptr   <= ptr_nxt;
      vld_q <= {vld_q[ROM_LAT-1:0], any};
      id_q  <= {id_q[ROM_LAT-1:0], win};
      if (any)
        rom_address <= addr[int'(win)*ADDR_W +: ADDR_W];
    end
  end

  assign rd_valid = vld_q[ROM_LAT];
  assign rd_id    = id_q[ROM_LAT];
  assign rd_data  = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: ROM_LAT=1 and ROM_LAT=2 instances.
// Expectations follow SPRITE_ARB_PRIO0_EN when it is defined.
module tb_sprite_rom_arbiter;

  logic vga_clk = 1'b0;
  logic reset_n;
  always #5 vga_clk = ~vga_clk;

  logic [3:0]  req1, gnt1, q1, d1;
  logic [31:0] addr1;
  logic [7:0]  ra1;
  logic        rv1;
  logic [1:0]  id1;

  logic [3:0]  req2, gnt2, q2, q2a, d2;
  logic [31:0] addr2;
  logic [7:0]  ra2;
  logic        rv2;
  logic [1:0]  id2;

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(4), .ROM_LAT(1)) u1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req1), .addr(addr1),
    .gnt(gnt1), .rom_address(ra1), .rom_q(q1), .rd_valid(rv1),
    .rd_id(id1), .rd_data(d1));

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(4), .ROM_LAT(2)) u2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req2), .addr(addr2),
    .gnt(gnt2), .rom_address(ra2), .rom_q(q2), .rd_valid(rv2),
    .rd_id(id2), .rd_data(d2));

  // ROM models: word = low nibble of the address
  always @(posedge vga_clk) q1 <= ra1[3:0];
  always @(posedge vga_clk) begin
    q2a <= ra2[3:0];
    q2  <= q2a;
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] addr;
    logic [3:0]  gnt;
    logic        rv;
    logic [1:0]  id;
    logic [3:0]  data;
    logic [7:0]  ra;
  } vec_t;

  vec_t vq[$];
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] AF = 32'h3332_3130;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [31:0] a,
                     input logic [3:0] g, input logic v,
                     input logic [1:0] i, input logic [3:0] d,
                     input logic [7:0] ra);
    vec_t t;
    t.req = r; t.addr = a; t.gnt = g; t.rv = v;
    t.id = i; t.data = d; t.ra = ra;
    vq.push_back(t);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      @(posedge vga_clk);
      #1;
      req1  = vq[i].req;
      addr1 = vq[i].addr;
      @(negedge vga_clk);
      chk($sformatf("%s[%0d].gnt", tag, i), 32'(gnt1), 32'(vq[i].gnt));
      chk($sformatf("%s[%0d].rd_valid", tag, i), 32'(rv1), 32'(vq[i].rv));
      chk($sformatf("%s[%0d].rom_address", tag, i), 32'(ra1), 32'(vq[i].ra));
      if (vq[i].rv) begin
        chk($sformatf("%s[%0d].rd_id", tag, i), 32'(id1), 32'(vq[i].id));
        chk($sformatf("%s[%0d].rd_data", tag, i), 32'(d1), 32'(vq[i].data));
      end
    end
    vq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rs;
    reset_n = 1'b0;
    req1 = '0; addr1 = '0;
    req2 = '0; addr2 = '0;
    repeat (2) @(negedge vga_clk);
    chk("rst.rd_valid", 32'(rv1), 32'd0);
    chk("rst.rd_id", 32'(id1), 32'd0);
    chk("rst.rom_address", 32'(ra1), 32'd0);
    chk("rst.rd_valid2", 32'(rv2), 32'd0);
    @(posedge vga_clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 10; i++) add(4'h0, 32'h0, 4'h0, 0, 0, 0, 8'h00);
`ifdef SPRITE_ARB_PRIO0_EN
    add(4'hF, AF, 4'h1, 0, 0, 0, 8'h00);
    add(4'hF, AF, 4'h1, 0, 0, 0, 8'h30);
    for (int i = 0; i < 6; i++) add(4'hF, AF, 4'h1, 1, 0, 0, 8'h30);
    add(4'h0, AF, 4'h0, 1, 0, 0, 8'h30);
    add(4'h0, AF, 4'h0, 1, 0, 0, 8'h30);
    add(4'h0, AF, 4'h0, 0, 0, 0, 8'h30);
    rs = 8'h30;
`else
    add(4'hF, AF, 4'h1, 0, 0, 0, 8'h00);
    add(4'hF, AF, 4'h2, 0, 0, 0, 8'h30);
    add(4'hF, AF, 4'h4, 1, 0, 0, 8'h31);
    add(4'hF, AF, 4'h8, 1, 1, 1, 8'h32);
    add(4'hF, AF, 4'h1, 1, 2, 2, 8'h33);
    add(4'hF, AF, 4'h2, 1, 3, 3, 8'h30);
    add(4'hF, AF, 4'h4, 1, 0, 0, 8'h31);
    add(4'hF, AF, 4'h8, 1, 1, 1, 8'h32);
    add(4'h0, AF, 4'h0, 1, 2, 2, 8'h33);
    add(4'h0, AF, 4'h0, 1, 3, 3, 8'h33);
    add(4'h0, AF, 4'h0, 0, 0, 0, 8'h33);
    rs = 8'h33;
`endif
    add(4'h4, 32'h0010_0000, 4'h4, 0, 0, 0, rs);
    add(4'h4, 32'h0011_0000, 4'h4, 0, 0, 0, 8'h10);
    add(4'h4, 32'h0012_0000, 4'h4, 1, 2, 0, 8'h11);
    add(4'h4, 32'h0013_0000, 4'h4, 1, 2, 1, 8'h12);
    add(4'h0, 32'h0, 4'h0, 1, 2, 2, 8'h13);
    add(4'h0, 32'h0, 4'h0, 1, 2, 3, 8'h13);
    add(4'h0, 32'h0, 4'h0, 0, 0, 0, 8'h13);
    run_vecs("p1");

    // ROM_LAT=2: single read on requester 1
    @(posedge vga_clk);
    #1 req2 = 4'h2; addr2 = 32'h0000_0700;
    @(negedge vga_clk);
    chk("lat2.gnt", 32'(gnt2), 32'h2);
    chk("lat2.rv_t0", 32'(rv2), 32'd0);
    @(posedge vga_clk);
    #1 req2 = 4'h0;
    @(negedge vga_clk);
    chk("lat2.rom_address", 32'(ra2), 32'h07);
    chk("lat2.rv_t1", 32'(rv2), 32'd0);
    chk("lat2.gnt_idle", 32'(gnt2), 32'h0);
    @(negedge vga_clk);
    chk("lat2.rv_t2", 32'(rv2), 32'd0);
    @(negedge vga_clk);
    chk("lat2.rv_t3", 32'(rv2), 32'd1);
    chk("lat2.rd_id", 32'(id2), 32'd1);
    chk("lat2.rd_data", 32'(d2), 32'd7);
    @(negedge vga_clk);
    chk("lat2.rv_t4", 32'(rv2), 32'd0);

    // Reset while streaming
    @(posedge vga_clk);
    #1 req1 = 4'hF; addr1 = AF;
    @(posedge vga_clk);
    @(posedge vga_clk);
    #2 chk("mid.pre_rv", 32'(rv1), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid.rv_async", 32'(rv1), 32'd0);
    chk("mid.ra_async", 32'(ra1), 32'd0);
    chk("mid.gnt_in_rst", 32'(gnt1), 32'h1);
    req1 = 4'h0;
    repeat (2) @(posedge vga_clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge vga_clk);
      chk($sformatf("post[%0d].rd_valid", i), 32'(rv1), 32'd0);
      chk($sformatf("post[%0d].rom_address", i), 32'(ra1), 32'd0);
    end

    // Pointer restart, then a request set that drops requester 0
`ifdef SPRITE_ARB_PRIO0_EN
    add(4'hF, AF, 4'h1, 0, 0, 0, 8'h00);
    add(4'hF, AF, 4'h1, 0, 0, 0, 8'h30);
    add(4'hF, AF, 4'h1, 1, 0, 0, 8'h30);
    add(4'hE, AF, 4'h2, 1, 0, 0, 8'h30);
    add(4'hE, AF, 4'h4, 1, 0, 0, 8'h31);
    add(4'hE, AF, 4'h8, 1, 1, 1, 8'h32);
    add(4'h0, AF, 4'h0, 1, 2, 2, 8'h33);
    add(4'h0, AF, 4'h0, 1, 3, 3, 8'h33);
    add(4'h0, AF, 4'h0, 0, 0, 0, 8'h33);
`else
    add(4'hF, AF, 4'h1, 0, 0, 0, 8'h00);
    add(4'hF, AF, 4'h2, 0, 0, 0, 8'h30);
    add(4'hF, AF, 4'h4, 1, 0, 0, 8'h31);
    add(4'hE, AF, 4'h8, 1, 1, 1, 8'h32);
    add(4'hE, AF, 4'h2, 1, 2, 2, 8'h33);
    add(4'hE, AF, 4'h4, 1, 3, 3, 8'h31);
    add(4'h0, AF, 4'h0, 1, 1, 1, 8'h32);
    add(4'h0, AF, 4'h0, 1, 2, 2, 8'h32);
    add(4'h0, AF, 4'h0, 0, 0, 0, 8'h32);
`endif
    run_vecs("p2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

- Shares one synchronous single-port sprite ROM (palette-index ROM, registered read) among `N_REQ` requesters: tank, bullet and HUD sprite draw engines.
- Performs per-cycle round-robin arbitration with a valid/grant handshake and drives the ROM address.
- Returns each read word tagged with the requester ID, aligned to the ROM read latency.
- Sits between the sprite draw engines and the shared `*_rom` instance, running on the pixel clock.

## Interface

Parameters:

- `N_REQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default 8: ROM address width.
- `DATA_W`, default 4: ROM word width (palette index).
- `ROM_LAT`, default 1: ROM read latency in cycles from the address register to valid `rom_q`; legal values 1 or 2.

Ports:

- `vga_clk`, in, 1: sole clock; all state on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req`, in, `N_REQ`: request; `req[i]` high means `addr` slice i is valid.
- `addr`, in, `N_REQ*ADDR_W`: request addresses; slice i is bits `[i*ADDR_W +: ADDR_W]`.
- `gnt`, out, `N_REQ`: combinational one-hot grant. A transfer occurs on a rising edge where `req[i] & gnt[i]`.
- `rom_address`, out, `ADDR_W`: registered; connects to the ROM address port.
- `rom_q`, in, `DATA_W`: ROM read data.
- `rd_valid`, out, 1: `rd_data` carries a completed read this cycle.
- `rd_id`, out, `$clog2(N_REQ)`: requester that owns `rd_data`.
- `rd_data`, out, `DATA_W`: equals `rom_q`. Only meaningful when `rd_valid` is high.

## Operation

- Round-robin pointer `ptr`, range 0..N_REQ-1.
- Each cycle, `gnt` selects the first asserted `req` scanning `ptr, ptr+1, …` with wrap at N_REQ-1 → 0.
- `gnt` is all-zero when `req` is all-zero. At most one `gnt` bit is high.
- `gnt` depends only on the current-cycle `req` and `ptr`. `gnt[i]` never asserts without `req[i]`.
- On each transfer edge with winner w:
  - `rom_address` ← addr slice w.
  - `ptr` ← (w+1) mod N_REQ.
  - A tag {valid=1, id=w} enters a `ROM_LAT`-deep shift pipeline.
- On edges with no transfer:
  - `rom_address` holds its last value.
  - `ptr` holds.
  - A tag with valid=0 enters the pipeline.
- `rd_valid` and `rd_id` are the pipeline outputs. `rd_data` is `rom_q` passed through combinationally.
- A requester keeping `req` high after its grant is treated as a new request; back-to-back reads are allowed. With competition, it waits for the rotation.
- Requesters must hold `req` and `addr` stable until granted; the arbiter does not latch an ungranted request.
- Full throughput: one read per cycle, sustained.

## Timing

- Reset values (async assert, sync release): `rom_address`=0, `ptr`=0, all pipeline tags invalid, `rd_valid`=0, `rd_id`=0. `gnt` follows `req` combinationally, including during reset.
- Transfer at edge T: `rom_address` updates at T; `rd_valid`=1 with the matching `rd_id` for the single cycle following edge T+ROM_LAT.
- Grant-to-data latency is ROM_LAT cycles after the transfer edge. Example: ROM_LAT=1, request at edge 5 → data valid in the cycle after edge 6.
- Reset asserted mid-operation: in-flight tags are discarded immediately and `rd_valid` drops asynchronously. No read completes after reset release unless it is re-requested.
- Wrap-around: a grant to N_REQ-1 sets `ptr` to 0.
- Simultaneous requests are resolved in the same cycle, with no extra bubble.

## Configuration

- `SPRITE_ARB_PRIO0_EN` defined:
  - Requester 0 (the on-screen pixel path, which must never stall) has absolute priority: `req[0]` always wins.
  - A grant to 0 does not change `ptr`.
  - Requesters 1..N_REQ-1 round-robin among themselves. `ptr` ranges 1..N_REQ-1 and resets to 1.
- Not defined: pure round-robin across all requesters, exactly as described in Operation.

## Test plan

- Reset, then all `req`=0 for 10 cycles → `gnt`=0, `rd_valid`=0, `rom_address`=0.
- N_REQ=4, ROM_LAT=1, `req[2]` held for 4 cycles, addresses 0x10..0x13, ROM models q=addr[3:0] → `gnt`=0100 each cycle; `rd_valid` for 4 consecutive cycles, `rd_id`=2, `rd_data`=0,1,2,3.
- `req`=1111 held 8 cycles → grant order 0,1,2,3,0,1,2,3; `rd_id` follows the same order one cycle later.
- `SPRITE_ARB_PRIO0_EN` defined, `req`=1111 for 3 cycles then `req`=1110 for 3 cycles → grants 0,0,0,1,2,3.
- ROM_LAT=2, single request on `req[1]` at addr 0x07 → `rd_valid` for exactly one cycle, 2 edges after the transfer edge, `rd_id`=1, `rd_data`=7.
- `req`=1111 streaming, assert `reset_n`=0 one cycle after a transfer, release 2 cycles later with `req`=0 → no `rd_valid` pulse at any point after the reset assertion; `ptr` restarts at 0 (at 1 with the macro defined).
